// File: rtl/roulette_pkg.sv
// Shared types and default constants for the roulette datapath: spin controller
// and the downstream digit counter.
package roulette_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPIN  = 2'd1,
    DECEL = 2'd2
  } spin_state_t;

  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 240000;
  localparam int unsigned DEF_FAST_PERIOD     = 60000;
  localparam int unsigned DEF_DECEL_STEP      = 6000;
  localparam int unsigned DEF_SLOW_PERIOD     = 600000;
  localparam int unsigned DEF_CNT_W           = 24;

  localparam int unsigned DIGIT_W = 4;

endpackage

// File: rtl/roulette_spin_ctrl_if.sv
// Button input and spin status outputs of the roulette spin controller.
interface roulette_spin_ctrl_if;
  logic btn_in;
  logic step_out;
  logic spinning;
  logic done;
  logic btn_level;

  modport master (
    output btn_in,
    input  step_out, spinning, done, btn_level
  );

  modport slave (
    input  btn_in,
    output step_out, spinning, done, btn_level
  );
endinterface

// File: rtl/roulette_spin_ctrl_btn_debounce.sv
// Button synchronizer and debouncer; emits the debounced level plus single-cycle
// press/release strobes aligned with the edge where the level changes.
module btn_debounce
  import roulette_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned STAB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [STAB_W-1:0]      stabCnt_q, stabCnt_d;
  logic                   level_q, level_d;
  logic                   syncBit, differs, toggle;

  assign syncBit = sync_q[SYNC_STAGES-1];
  assign differs = (syncBit != level_q);
  assign toggle  = differs && (stabCnt_q == STAB_W'(DEBOUNCE_CYCLES - 1));

  // Any sample matching the current level restarts the stability count.
  always_comb begin
    stabCnt_d = '0;
    level_d   = level_q;
    if (toggle) begin
      level_d = ~level_q;
    end else if (differs) begin
      stabCnt_d = stabCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q    <= '0;
      stabCnt_q <= '0;
      level_q   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_i};
      stabCnt_q <= stabCnt_d;
      level_q   <= level_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = toggle & ~level_q;
  assign release_o = toggle &  level_q;

endmodule

// File: rtl/roulette_spin_ctrl.sv
// Spin controller: press-and-hold spins at a fixed step rate, release decays the
// rate linearly until the roulette stops and a done pulse is issued.
module roulette_spin_ctrl
  import roulette_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned FAST_PERIOD     = DEF_FAST_PERIOD,
  parameter int unsigned DECEL_STEP      = DEF_DECEL_STEP,
  parameter int unsigned SLOW_PERIOD     = DEF_SLOW_PERIOD,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input logic           clk,
  input logic           rst_n,
  roulette_spin_ctrl_if.slave bus
);

  spin_state_t      state_q, state_d;
  logic [CNT_W-1:0] tickCnt_q, tickCnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W:0]   nextPeriod;
  logic             step_q, step_d;
  logic             done_q, done_d;
  logic             spinning_q;
  logic             btnLevel, pressPulse, releasePulse;
  logic             terminal;

  btn_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_i    (bus.btn_in),
    .level_o  (btnLevel),
    .press_o  (pressPulse),
    .release_o(releasePulse)
  );

  assign terminal   = (state_q != IDLE) && (tickCnt_q == period_q - 1'b1);
  assign nextPeriod = {1'b0, period_q} + (CNT_W+1)'(DECEL_STEP);

  // A press in DECEL takes priority over the deceleration bookkeeping, but the
  // step already due on that terminal tick is still emitted.
  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    tickCnt_d = terminal ? '0 : tickCnt_q + 1'b1;
    step_d    = terminal;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        tickCnt_d = '0;
        if (pressPulse) begin
          state_d  = SPIN;
          period_d = CNT_W'(FAST_PERIOD);
        end
      end
      SPIN: begin
        if (releasePulse) state_d = DECEL;
      end
      DECEL: begin
        if (pressPulse) begin
          state_d   = SPIN;
          period_d  = CNT_W'(FAST_PERIOD);
          tickCnt_d = '0;
        end else if (terminal) begin
          if (nextPeriod < (CNT_W+1)'(SLOW_PERIOD)) begin
            period_d = nextPeriod[CNT_W-1:0];
          end else begin
            state_d   = IDLE;
            tickCnt_d = '0;
            done_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tickCnt_q  <= '0;
      period_q   <= '0;
      step_q     <= 1'b0;
      done_q     <= 1'b0;
      spinning_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tickCnt_q  <= tickCnt_d;
      period_q   <= period_d;
      step_q     <= step_d;
      done_q     <= done_d;
      spinning_q <= (state_d != IDLE);
    end
  end

  assign bus.step_out  = step_q;
  assign bus.done      = done_q;
  assign bus.spinning  = spinning_q;
  assign bus.btn_level = btnLevel;

endmodule

// File: tb/tb_roulette_spin_ctrl.sv
// Bench for roulette_spin_ctrl: reset/bounce vector table, hand-timed spin and
// deceleration sequences, then random button activity against an event model.
module tb_roulette_spin_ctrl;

  localparam int SYNC  = 2;
  localparam int DEB   = 4;
  localparam int FAST  = 4;
  localparam int DSTEP = 2;
  localparam int SLOW  = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  roulette_spin_ctrl_if bus ();

  roulette_spin_ctrl #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .FAST_PERIOD    (FAST),
    .DECEL_STEP     (DSTEP),
    .SLOW_PERIOD    (SLOW),
    .CNT_W          (24)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int doneCount   = 0;
  int stepCount   = 0;

  // Event-level reference: the next step is scheduled at an absolute edge number.
  int               edgeN     = 0;
  logic [SYNC-1:0]  mSync     = '0;
  int               mRun      = 0;
  logic             mLevel    = 1'b0;
  logic             mActive   = 1'b0;
  logic             mDecel    = 1'b0;
  int               mPeriod   = 0;
  int               mTermEdge = 0;
  logic             mStep     = 1'b0;
  logic             mDone     = 1'b0;

  always @(posedge clk) begin
    bit press, rel, term;
    edgeN++;
    press = 1'b0;
    rel   = 1'b0;
    if (!rst_n) begin
      mSync = '0; mRun = 0; mLevel = 1'b0; mActive = 1'b0; mDecel = 1'b0;
      mPeriod = 0; mStep = 1'b0; mDone = 1'b0;
    end else begin
      if (mSync[SYNC-1] != mLevel) begin
        mRun++;
        if (mRun == DEB) begin
          mLevel = ~mLevel;
          mRun   = 0;
          press  = mLevel;
          rel    = ~mLevel;
        end
      end else begin
        mRun = 0;
      end
      mSync = {mSync[SYNC-2:0], bus.btn_in};
      term  = mActive && (edgeN == mTermEdge);
      mStep = term;
      mDone = 1'b0;
      if (!mActive) begin
        if (press) begin
          mActive = 1'b1; mDecel = 1'b0; mPeriod = FAST; mTermEdge = edgeN + FAST;
        end
      end else if (press) begin
        mDecel = 1'b0; mPeriod = FAST; mTermEdge = edgeN + FAST;
      end else begin
        if (term) begin
          if (mDecel) begin
            if (mPeriod + DSTEP < SLOW) begin
              mPeriod   = mPeriod + DSTEP;
              mTermEdge = edgeN + mPeriod;
            end else begin
              mDone = 1'b1; mActive = 1'b0; mDecel = 1'b0;
            end
          end else begin
            mTermEdge = edgeN + mPeriod;
          end
        end
        if (rel && mActive) mDecel = 1'b1;
      end
    end
  end

  task automatic tick();
    logic [3:0] got, want;
    @(negedge clk);
    got  = {bus.step_out, bus.spinning, bus.done, bus.btn_level};
    want = {mStep, mActive, mDone, mLevel};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL model edge%0d: got {step,spin,done,lvl}=%b expected %b", edgeN, got, want);
    end
    if (bus.done === 1'b1) doneCount++;
    if (bus.step_out === 1'b1) stepCount++;
  endtask

  task automatic applyStimulus(input logic r, input logic b, input int n);
    rst_n      = r;
    bus.btn_in = b;
    repeat (n) tick();
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic waitStep(input string name, input int expected);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.step_out !== 1'b1 && n < 40);
    if (bus.step_out !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: no step within %0d cycles, expected gap %0d", name, n, expected);
    end else begin
      checkOutput(name, n, expected);
    end
  endtask

  task automatic waitLevel(input string name, input logic lvl, input int expected);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.btn_level !== lvl && n < 40);
    checkOutput(name, (bus.btn_level === lvl) ? n : -1, expected);
  endtask

  typedef struct {
    logic       rstN;
    logic       btn;
    int         n;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int d0, s0;
    bus.btn_in = 1'b0;

    // Reset with a toggling button, then short bounces that must be ignored.
    tbl.push_back('{1'b0, 1'b1, 1, 4'b0000});
    tbl.push_back('{1'b0, 1'b0, 1, 4'b0000});
    tbl.push_back('{1'b0, 1'b1, 1, 4'b0000});
    tbl.push_back('{1'b1, 1'b0, 1, 4'b0000});
    for (int k = 0; k < 3; k++) begin
      tbl.push_back('{1'b1, 1'b1, 2, 4'b0000});
      tbl.push_back('{1'b1, 1'b0, 3, 4'b0000});
    end
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].rstN, tbl[i].btn, tbl[i].n);
      checkOutput($sformatf("table[%0d]", i),
                  int'({bus.step_out, bus.spinning, bus.done, bus.btn_level}), int'(tbl[i].exp));
    end
    checkOutput("bounce_no_step", stepCount, 0);

    // Hold: level after sync+debounce, then steps every FAST cycles.
    bus.btn_in = 1'b1;
    waitLevel("level_rise_latency", 1'b1, SYNC + DEB);
    waitStep("first_step", FAST);
    checkOutput("spinning_hold", int'(bus.spinning), 1);
    for (int k = 0; k < 4; k++) waitStep($sformatf("hold_gap%0d", k), FAST);

    // Release: one more spin step, then decel gaps FAST, FAST+DSTEP, FAST+2*DSTEP.
    d0 = doneCount;
    bus.btn_in = 1'b0;
    waitStep("rel_spin_step", 4);
    waitStep("decel_step1", 4);
    waitStep("decel_step2", 6);
    checkOutput("no_early_done", doneCount - d0, 0);
    waitStep("decel_final", 8);
    checkOutput("final_done", int'(bus.done), 1);
    checkOutput("final_spinning", int'(bus.spinning), 0);
    s0 = stepCount; d0 = doneCount;
    applyStimulus(1'b1, 1'b0, 30);
    checkOutput("idle_no_step", stepCount - s0, 0);
    checkOutput("idle_no_done", doneCount - d0, 0);

    // Re-press landing on a decel terminal tick.
    bus.btn_in = 1'b1;
    waitLevel("repress_level", 1'b1, SYNC + DEB);
    waitStep("repress_first", FAST);
    d0 = doneCount;
    bus.btn_in = 1'b0;
    waitStep("repress_spin_step", 4);
    waitStep("repress_decel1", 4);
    bus.btn_in = 1'b1;
    waitStep("repress_coincide", 6);
    checkOutput("repress_coincide_done", int'(bus.done), 0);
    waitStep("repress_gap", FAST);
    checkOutput("repress_spinning", int'(bus.spinning), 1);
    checkOutput("repress_never_done", doneCount - d0, 0);

    // Reset in the middle of deceleration.
    bus.btn_in = 1'b0;
    waitStep("pre_reset_spin", 4);
    waitStep("pre_reset_decel", 4);
    applyStimulus(1'b1, 1'b0, 2);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("midreset_outputs",
                int'({bus.step_out, bus.spinning, bus.done, bus.btn_level}), 0);
    s0 = stepCount; d0 = doneCount;
    applyStimulus(1'b1, 1'b0, 40);
    checkOutput("post_reset_no_step", stepCount - s0, 0);
    checkOutput("post_reset_no_done", doneCount - d0, 0);

    // Random button activity with occasional resets.
    for (int s = 0; s < 160; s++) begin
      int unsigned len;
      logic        b;
      len = $urandom_range(1, 25);
      b   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) applyStimulus(1'b0, b, 1);
      applyStimulus(1'b1, b, int'(len));
    end
    applyStimulus(1'b1, 1'b0, 40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
